// File: rtl/nf10_axis_sim_monitor.sv
// AXI4-Stream sink/monitor: counts packets, keeps a ring of per-packet {byte length,
// first-beat tuser} records, drives an optional throttled tready and flags stability violations.
module nf10_axis_sim_monitor #(
  parameter int          C_S_AXIS_DATA_WIDTH  = 256,
  parameter int          C_S_AXIS_TUSER_WIDTH = 128,
  parameter int          C_COUNTER_WIDTH      = 8,
  parameter int          C_LOG_DEPTH          = 4,
  parameter int          C_READY_MODE         = 0,
  parameter logic [31:0] C_THROTTLE_PATTERN   = 32'hB6DB6DB6,
  parameter int          C_ACTIVITY_TIMEOUT   = 16
) (
  input  logic                              aclk,
  input  logic                              aresetn,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                              s_axis_tvalid,
  output logic                              s_axis_tready,
  input  logic                              s_axis_tlast,
  output logic [C_COUNTER_WIDTH-1:0]        counter,
  output logic                              activity_rec,
  input  logic [C_LOG_DEPTH-1:0]            rec_rd_addr,
  output logic [15:0]                       rec_rd_len,
  output logic [31:0]                       rec_rd_tuser,
  output logic                              rec_rd_valid,
  input  logic                              rec_clear,
  output logic                              rec_overflow,
  output logic                              proto_err
);
  localparam int STRB_W = C_S_AXIS_DATA_WIDTH / 8;
  localparam int DEPTH  = 1 << C_LOG_DEPTH;
  localparam int IDLE_W = $clog2(C_ACTIVITY_TIMEOUT + 1);

  typedef enum logic {IDLE, IN_PKT} state_t;

  state_t      state_q, state_d;
  logic        hs;
  logic [15:0] len_q, len_d, beat_len;
  logic [16:0] len_sum;
  logic [31:0] tuser_q, tuser_d;
  logic        commit;
  logic [15:0] commit_len;
  logic [31:0] commit_tuser;

  assign hs = s_axis_tvalid & s_axis_tready;

  always_comb begin
    beat_len = '0;
    for (int unsigned i = 0; i < STRB_W; i++)
      beat_len = beat_len + 16'(s_axis_tstrb[i]);
  end

  assign len_sum = {1'b0, len_q} + {1'b0, beat_len};

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    tuser_d      = tuser_q;
    commit       = 1'b0;
    commit_len   = '0;
    commit_tuser = '0;
    case (state_q)
      IDLE: begin
        if (hs) begin
          if (s_axis_tlast) begin
            commit       = 1'b1;
            commit_len   = beat_len;
            commit_tuser = s_axis_tuser[31:0];
          end else begin
            state_d = IN_PKT;
            len_d   = beat_len;
            tuser_d = s_axis_tuser[31:0];
          end
        end
      end
      IN_PKT: begin
        if (hs) begin
          len_d = len_sum[16] ? 16'hFFFF : len_sum[15:0];
          if (s_axis_tlast) begin
            commit       = 1'b1;
            commit_len   = len_d;
            commit_tuser = tuser_q;
            state_d      = IDLE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q <= IDLE;
      len_q   <= '0;
      tuser_q <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      tuser_q <= tuser_d;
    end
  end

  logic [15:0]            mem_len   [DEPTH];
  logic [31:0]            mem_tuser [DEPTH];
  logic [DEPTH-1:0]       valid_q;
  logic [C_LOG_DEPTH-1:0] wr_ptr, wr_idx;

  // A clear in the commit cycle restarts the ring, so that commit lands at entry 0.
  assign wr_idx = rec_clear ? '0 : wr_ptr;

  always_ff @(posedge aclk) begin
    if (commit) begin
      mem_len[wr_idx]   <= commit_len;
      mem_tuser[wr_idx] <= commit_tuser;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      valid_q      <= '0;
      wr_ptr       <= '0;
      rec_overflow <= 1'b0;
      counter      <= '0;
    end else begin
      if (rec_clear) begin
        valid_q      <= '0;
        wr_ptr       <= '0;
        rec_overflow <= 1'b0;
      end
      if (commit) begin
        valid_q[wr_idx] <= 1'b1;
        wr_ptr          <= wr_idx + C_LOG_DEPTH'(1);
        counter         <= counter + C_COUNTER_WIDTH'(1);
        if (valid_q[wr_ptr] && !rec_clear)
          rec_overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      rec_rd_len   <= '0;
      rec_rd_tuser <= '0;
      rec_rd_valid <= 1'b0;
    end else begin
      rec_rd_valid <= valid_q[rec_rd_addr];
      rec_rd_len   <= valid_q[rec_rd_addr] ? mem_len[rec_rd_addr]   : '0;
      rec_rd_tuser <= valid_q[rec_rd_addr] ? mem_tuser[rec_rd_addr] : '0;
    end
  end

  logic [31:0] thr_q;
  logic        rdy_q;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      thr_q <= C_THROTTLE_PATTERN;
      rdy_q <= 1'b0;
    end else begin
      thr_q <= {thr_q[0], thr_q[31:1]};
      rdy_q <= (C_READY_MODE == 1) ? thr_q[0] : 1'b1;
    end
  end

  assign s_axis_tready = rdy_q;

  logic [IDLE_W-1:0] idle_q;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      idle_q       <= '0;
      activity_rec <= 1'b0;
    end else if (hs) begin
      idle_q       <= IDLE_W'(C_ACTIVITY_TIMEOUT);
      activity_rec <= 1'b1;
    end else if (idle_q != '0) begin
      idle_q <= idle_q - IDLE_W'(1);
      if (idle_q == IDLE_W'(1))
        activity_rec <= 1'b0;
    end
  end

  logic                            stall_q;
  logic [C_S_AXIS_DATA_WIDTH-1:0]  data_q;
  logic [STRB_W-1:0]               strb_q;
  logic [C_S_AXIS_TUSER_WIDTH-1:0] user_q;
  logic                            last_q;

  always_ff @(posedge aclk) begin
    data_q <= s_axis_tdata;
    strb_q <= s_axis_tstrb;
    user_q <= s_axis_tuser;
    last_q <= s_axis_tlast;
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      stall_q   <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      stall_q <= s_axis_tvalid & ~s_axis_tready;
      if (stall_q && (!s_axis_tvalid || s_axis_tdata != data_q || s_axis_tstrb != strb_q ||
                      s_axis_tuser != user_q || s_axis_tlast != last_q))
        proto_err <= 1'b1;
    end
  end

endmodule

// File: doc/nf10_axis_sim_monitor.md
# nf10_axis_sim_monitor

Parametrised AXI4-Stream sink/monitor for the nf10 simulation and debug flow: terminates one stream, counts completed packets, flags activity, and keeps a per-packet record ring readable by the testbench. It generalises the plain packet recorder with configurable counter width, a backpressure-throttle mode, per-packet byte-length/TUSER capture, and a sticky AXI protocol checker. The block is synthesizable, so it also serves as an on-chip tap.

## Interface
- C_S_AXIS_DATA_WIDTH, 256, tdata width; a multiple of 8, up to 256.
- C_S_AXIS_TUSER_WIDTH, 128, tuser width; at least 32.
- C_COUNTER_WIDTH, 8, width of the packet counter.
- C_LOG_DEPTH, 4, log2 of the record-ring entries.
- C_READY_MODE, 0, 0 = tready is always 1 out of reset; 1 = tready follows a rotating throttle pattern.
- C_THROTTLE_PATTERN, 32'hB6DB6DB6, 32-bit ready pattern used in mode 1; bit 0 is applied first.
- C_ACTIVITY_TIMEOUT, 16, number of idle cycles before activity_rec drops; at least 1.
- aclk  in  1  single clock; all logic is on the rising edge.
- aresetn  in  1  synchronous, active-low reset.
- s_axis_tdata  in  C_S_AXIS_DATA_WIDTH  stream data.
- s_axis_tstrb  in  C_S_AXIS_DATA_WIDTH/8  byte strobes.
- s_axis_tuser  in  C_S_AXIS_TUSER_WIDTH  sideband; only bits [31:0] are captured.
- s_axis_tvalid  in  1  valid.
- s_axis_tready  out  1  ready.
- s_axis_tlast  in  1  end of packet.
- counter  out  C_COUNTER_WIDTH  completed packets, modulo 2^C_COUNTER_WIDTH.
- activity_rec  out  1  high while beats have been recently accepted.
- rec_rd_addr  in  C_LOG_DEPTH  ring read index.
- rec_rd_len  out  16  byte length of the selected record.
- rec_rd_tuser  out  32  first-beat tuser[31:0] of the selected record.
- rec_rd_valid  out  1  the selected entry has been written since reset or clear.
- rec_clear  in  1  one-cycle pulse that invalidates all records and clears overflow.
- rec_overflow  out  1  sticky; the ring wrapped over a valid entry.
- proto_err  out  1  sticky; an AXI stability violation was seen.

## Operation
- Handshake: hs = s_axis_tvalid & s_axis_tready.
- The state machine is IDLE or IN_PKT; reset puts it in IDLE.
  - IDLE with hs and !tlast: latch tuser[31:0]; len = popcount(tstrb); go to IN_PKT.
  - IDLE with hs and tlast: a single-beat packet; commit immediately and stay in IDLE.
  - IN_PKT with hs: len += popcount(tstrb), saturating at 16'hFFFF. With tlast, commit and return to IDLE.
- Commit:
  - Write {len, tuser} to entry wr_ptr and set that entry's valid bit.
  - wr_ptr advances by 1, wrapping at 2^C_LOG_DEPTH.
  - If the entry was already valid, set rec_overflow.
  - counter increments by 1, wrapping to 0.
- rec_clear:
  - Clears all valid bits, wr_ptr and rec_overflow.
  - Does not touch counter or the FSM.
  - If a commit lands in the same cycle, the commit wins for its entry, which ends up at index 0; wr_ptr becomes 1.
- Throttle (mode 1):
  - A 32-bit register is loaded with C_THROTTLE_PATTERN at reset and rotates right by 1 every cycle.
  - s_axis_tready = reg[0], registered.
  - Ready does not depend on tvalid.
- Protocol check: proto_err sets when the previous cycle had tvalid=1 and tready=0, and this cycle either drops tvalid or changes tdata, tstrb, tuser or tlast.
- Reset mid-packet discards the partial packet; nothing is committed.

## Timing
- Reset values:
  - counter = 0, activity_rec = 0, rec_overflow = 0, proto_err = 0, rec_rd_valid = 0.
  - rec_rd_len = 0, rec_rd_tuser = 0.
  - s_axis_tready = 0 during reset. After reset: 1 in mode 0; pattern bit 0 in the first cycle after reset in mode 1.
- counter and the ring entry update on the edge following the tlast hs cycle, i.e. visible 1 cycle after.
- rec_rd_* are registered: 1-cycle latency from rec_rd_addr. Reading the entry being committed in the same cycle returns the old contents.
- activity_rec:
  - Rises on the edge after any hs.
  - An idle counter reloads on every hs.
  - Falls after C_ACTIVITY_TIMEOUT consecutive cycles without hs.
- Back-to-back packets at full rate, with tlast followed directly by a new first beat, need no idle cycle.

## Test plan
- Mode 0: three packets of 2, 1 and 4 beats at 256-bit width with full strobes -> counter = 3; records 0/1/2 have len 64/32/128; tuser is captured from each first beat only.
- Partial strobe: final-beat tstrb = 32'h0000_000F on a 2-beat packet -> len = 36.
- Wrap: C_LOG_DEPTH = 2, C_COUNTER_WIDTH = 2, 5 packets -> counter = 1; rec_overflow = 1; entry 0 holds packet 5.
- Mode 1 with the default pattern and tvalid held high -> tready sequence 0,1,1,0,1,1,...; all beats accepted in order; proto_err stays 0.
- Violation: drive tvalid=1 while tready=0, then change tdata on the next cycle -> proto_err = 1 and sticky until aresetn.
- Timeout and reset: after the last hs, activity_rec falls exactly C_ACTIVITY_TIMEOUT cycles later. Assert aresetn=0 mid-packet -> no commit, counter = 0, and the FSM restarts in IDLE.
